// File: rtl/nor_test_sequencer_if.sv
// Bus between the NOR self-test sequencer, its vector ROM and the gate under test.
// The master side (sequencer) addresses the ROM and drives the gate inputs.
interface nor_test_sequencer_if #(
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] vec_addr;
   logic [2:0]        vec_data;
   logic              dut_a;
   logic              dut_b;
   logic              dut_w;

   modport master (
      output vec_addr, dut_a, dut_b,
      input  vec_data, dut_w
   );

   modport slave (
      input  vec_addr, dut_a, dut_b,
      output vec_data, dut_w
   );
endinterface

// File: rtl/nor_test_sequencer.sv
// Self-test controller for a 2-input NOR gate: walks a {a,b,expected} vector ROM,
// drives the gate, waits a settle window, and tallies mismatches.
module nor_test_sequencer #(
   parameter int NUM_VECTORS   = 24,
   parameter int ADDR_W        = 5,
   parameter int CNT_W         = 11,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   nor_test_sequencer_if.master       bus,
   output logic                       busy,
   output logic                       done,
   output logic                       mismatch,
   output logic [CNT_W-1:0]           err_count,
   output logic [CNT_W-1:0]           vec_count,
   output logic [ADDR_W-1:0]          first_fail_addr,
   output logic                       first_fail_vld
);

   localparam int SET_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_VECTORS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_APPLY, S_WAIT, S_CHECK, S_DONE
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic              drv_a;
   logic              drv_b;
   logic              exp_w;
   logic [SET_W-1:0]  settle;
   logic              fail;

   assign bus.vec_addr = addr;
   assign bus.dut_a    = drv_a;
   assign bus.dut_b    = drv_b;
   assign fail         = (bus.dut_w != exp_w);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= S_IDLE;
         addr            <= '0;
         drv_a           <= 1'b0;
         drv_b           <= 1'b0;
         exp_w           <= 1'b0;
         settle          <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         mismatch        <= 1'b0;
         err_count       <= '0;
         vec_count       <= '0;
         first_fail_addr <= '0;
         first_fail_vld  <= 1'b0;
      end else begin
         mismatch <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state           <= S_FETCH;
                  busy            <= 1'b1;
                  done            <= 1'b0;
                  addr            <= '0;
                  err_count       <= '0;
                  vec_count       <= '0;
                  first_fail_addr <= '0;
                  first_fail_vld  <= 1'b0;
               end else if (state == S_DONE) begin
                  done <= 1'b1;
               end
            end
            // ROM registers the address during this cycle; data arrives in APPLY
            S_FETCH: state <= S_APPLY;
            S_APPLY: begin
               drv_a  <= bus.vec_data[2];
               drv_b  <= bus.vec_data[1];
               exp_w  <= bus.vec_data[0];
               settle <= SET_W'(SETTLE_CYCLES);
               state  <= S_WAIT;
            end
            S_WAIT: begin
               settle <= settle - SET_W'(1);
               if (settle == SET_W'(1)) state <= S_CHECK;
            end
            S_CHECK: begin
               if (fail) begin
                  mismatch <= 1'b1;
                  if (err_count != '1) err_count <= err_count + CNT_W'(1);
                  if (!first_fail_vld) begin
                     first_fail_addr <= addr;
                     first_fail_vld  <= 1'b1;
                  end
               end
               vec_count <= vec_count + CNT_W'(1);
               // Address compare rather than vec_count, which may legitimately wrap
               if (addr == LAST_ADDR) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
               end else begin
                  addr  <= addr + ADDR_W'(1);
                  state <= S_FETCH;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nor_test_sequencer.sv
// Bench for nor_test_sequencer: table of ROM/gate scenarios on the default-size
// instance, a narrow-counter instance for saturation, plus reset and restart sequences.
module tb_nor_test_sequencer;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic start_s = 1'b0;
   int   mode = 0;

   always #5 clk = ~clk;

   logic [2:0] rom [0:31];

   // Default instance
   nor_test_sequencer_if #(.ADDR_W(5)) bus0 ();
   logic        busy, done, mismatch, first_fail_vld;
   logic [10:0] err_count, vec_count;
   logic [4:0]  first_fail_addr;

   nor_test_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .bus(bus0),
      .busy(busy), .done(done), .mismatch(mismatch),
      .err_count(err_count), .vec_count(vec_count),
      .first_fail_addr(first_fail_addr), .first_fail_vld(first_fail_vld)
   );

   always_ff @(posedge clk) bus0.vec_data <= rom[bus0.vec_addr];
   assign bus0.dut_w = (mode == 0) ? ~(bus0.dut_a | bus0.dut_b) : (mode == 2);

   // Narrow instance: 2-bit counters, 8 vectors, gate always wrong (OR instead of NOR)
   nor_test_sequencer_if #(.ADDR_W(3)) bus1 ();
   logic       busy_s, done_s, mismatch_s, ffv_s;
   logic [1:0] err_s, vc_s;
   logic [2:0] ffa_s;

   nor_test_sequencer #(.NUM_VECTORS(8), .ADDR_W(3), .CNT_W(2), .SETTLE_CYCLES(1)) dut_s (
      .clk(clk), .reset(reset), .start(start_s), .bus(bus1),
      .busy(busy_s), .done(done_s), .mismatch(mismatch_s),
      .err_count(err_s), .vec_count(vc_s),
      .first_fail_addr(ffa_s), .first_fail_vld(ffv_s)
   );

   always_ff @(posedge clk) bus1.vec_data <= rom[{2'b00, bus1.vec_addr}];
   assign bus1.dut_w = bus1.dut_a | bus1.dut_b;

   typedef struct {
      int          mode;
      logic [31:0] mask;
      bit          glitch;
      int          err;
      int          ffa;
      int          ffv;
      int          pulses;
   } vec_t;

   typedef struct {
      int err;
      int vc;
      int ffa;
      int ffv;
      int edges;
      int pulses;
   } res_t;

   vec_t tbl [5];
   res_t sb [$];
   int   n_cmp = 0;
   int   n_fail = 0;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic load_rom(input logic [31:0] mask);
      logic a, b;
      for (int i = 0; i < 32; i++) begin
         a = i[1];
         b = i[0];
         rom[i] = (i < 24) ? {a, b, ~(a | b) ^ mask[i]} : 3'b000;
      end
   endtask

   task automatic run_main(input bit glitch, input res_t req);
      res_t got;
      int   edges;
      int   pulses;
      sb.push_back(req);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("start_busy", int'(busy), 1);
      check("start_done_clr", int'(done), 0);
      check("start_err_clr", int'(err_count), 0);
      check("start_vc_clr", int'(vec_count), 0);
      check("start_ffv_clr", int'(first_fail_vld), 0);
      edges = 0;
      pulses = 0;
      while (!done && edges < 400) begin
         @(posedge clk);
         #1;
         edges++;
         if (mismatch) pulses++;
         start = glitch && (edges == 9 || edges == 29);
      end
      start = 1'b0;
      got = sb.pop_front();
      check("done_edge", edges, got.edges);
      check("err_count", int'(err_count), got.err);
      check("vec_count", int'(vec_count), got.vc);
      check("first_fail_addr", int'(first_fail_addr), got.ffa);
      check("first_fail_vld", int'(first_fail_vld), got.ffv);
      check("mismatch_pulses", pulses, got.pulses);
      check("done_busy_low", int'(busy), 0);
   endtask

   initial begin
      res_t r;
      int   edges;
      int   pulses;

      tbl[0] = '{mode: 0, mask: 32'h0,                     glitch: 0, err: 0,  ffa: 0, ffv: 0, pulses: 0};
      tbl[1] = '{mode: 1, mask: 32'h0,                     glitch: 0, err: 6,  ffa: 0, ffv: 1, pulses: 6};
      tbl[2] = '{mode: 0, mask: (32'h1 << 5) | (32'h1 << 17), glitch: 0, err: 2,  ffa: 5, ffv: 1, pulses: 2};
      tbl[3] = '{mode: 2, mask: 32'h0,                     glitch: 0, err: 18, ffa: 1, ffv: 1, pulses: 18};
      tbl[4] = '{mode: 0, mask: 32'h0,                     glitch: 1, err: 0,  ffa: 0, ffv: 0, pulses: 0};

      load_rom(32'h0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_addr", int'(bus0.vec_addr), 0);
      check("rst_err", int'(err_count), 0);
      @(negedge clk);
      reset = 1'b1;

      // Table scenarios; every row after the first restarts from DONE
      for (int k = 0; k < 5; k++) begin
         mode = tbl[k].mode;
         load_rom(tbl[k].mask);
         r = '{err: tbl[k].err, vc: 24, ffa: tbl[k].ffa, ffv: tbl[k].ffv,
               edges: 97, pulses: tbl[k].pulses};
         run_main(tbl[k].glitch, r);
      end

      // DONE holds its results while start stays low
      repeat (5) @(posedge clk);
      #1;
      check("done_held", int'(done), 1);
      check("vc_held", int'(vec_count), 24);

      // Mid-run asynchronous reset with stuck-at-0 gate
      mode = 1;
      load_rom(32'h0);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (38) @(posedge clk);
      @(posedge clk);
      #1;
      check("pre_rst_err", int'(err_count), 3);
      check("pre_rst_vc", int'(vec_count), 9);
      @(posedge clk);
      reset = 1'b0;
      #1;
      check("async_busy", int'(busy), 0);
      check("async_err", int'(err_count), 0);
      check("async_vc", int'(vec_count), 0);
      check("async_ffv", int'(first_fail_vld), 0);
      check("async_addr", int'(bus0.vec_addr), 0);
      check("async_dut_ab", int'({bus0.dut_a, bus0.dut_b}), 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("idle_busy", int'(busy), 0);
      check("idle_done", int'(done), 0);
      check("idle_addr", int'(bus0.vec_addr), 0);

      mode = 0;
      r = '{err: 0, vc: 24, ffa: 0, ffv: 0, edges: 97, pulses: 0};
      run_main(1'b0, r);

      // Narrow counters: err_count saturates, vec_count wraps
      load_rom(32'h0);
      sb.push_back('{err: 3, vc: 0, ffa: 0, ffv: 1, edges: 33, pulses: 8});
      @(negedge clk);
      start_s = 1'b1;
      @(posedge clk);
      #1;
      start_s = 1'b0;
      check("s_start_busy", int'(busy_s), 1);
      edges = 0;
      pulses = 0;
      while (!done_s && edges < 200) begin
         @(posedge clk);
         #1;
         edges++;
         if (mismatch_s) pulses++;
      end
      r = sb.pop_front();
      check("s_done_edge", edges, r.edges);
      check("s_err_sat", int'(err_s), r.err);
      check("s_vc_wrap", int'(vc_s), r.vc);
      check("s_ffa", int'(ffa_s), r.ffa);
      check("s_ffv", int'(ffv_s), r.ffv);
      check("s_pulses", pulses, r.pulses);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
